rej_bounded_sampler: RTL

- Downstream stage of the ExpandS controller. Consumes the SHAKE256 squeeze stream seeded with rho_prime and performs ML-DSA RejBoundedPoly.
- Converts accepted 4-bit nibbles into coefficients in [-eta, eta], represented mod q.
- Streams exactly N coefficients per polynomial to the s1/s2 storage, then pulses done.
- Issues input-ready to request more SHAKE words and applies backpressure from the coefficient sink.

---
 rtl/rej_bounded_sampler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rej_bounded_sampler.sv
// rtl/rej_bounded_sampler.sv - ML-DSA RejBoundedPoly sampler over a SHAKE256 squeeze stream.
// Turns accepted nibbles into coefficients in [-eta, eta] mod Q and streams N per polynomial.
module rej_bounded_sampler #(
  parameter int SHA_W  = 64,
  parameter int Q      = 8380417,
  parameter int N      = 256,
  parameter int COEF_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              eta_sel,
  input  logic [SHA_W-1:0]  sha_data,
  input  logic              sha_valid,
  output logic              sha_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [7:0]        coef_idx,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done
);

  localparam int NIBS  = SHA_W / 4;
  localparam int NIB_W = $clog2(NIBS);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               eta4;
  logic [SHA_W-1:0]   word_q;
  logic [NIB_W-1:0]   nib_idx;
  logic [CNT_W-1:0]   count;

  logic [3:0]         z;
  logic [2:0]         z_mod5;
  logic               accept;
  logic               neg;
  logic [3:0]         mag;
  logic [COEF_W-1:0]  coef_val;
  logic               handshake;
  logic               step;
  logic               last_nib;
  logic               last_coef;

  // Reduction of a 4-bit value mod 5 by two conditional subtractions.
  function automatic logic [2:0] mod5(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (r >= 4'd10)
      r = r - 4'd10;
    else if (r >= 4'd5)
      r = r - 4'd5;
    return r[2:0];
  endfunction

  assign z      = word_q[4*int'(nib_idx) +: 4];
  assign z_mod5 = mod5(z);
  assign accept = eta4 ? (z < 4'd9) : (z < 4'd15);

  // Split the signed value into sign and magnitude so the mod-Q map is a single subtract.
  always_comb begin
    neg = 1'b0;
    mag = 4'd0;
    if (eta4) begin
      if (z <= 4'd4) begin
        mag = 4'd4 - z;
      end else begin
        mag = z - 4'd4;
        neg = 1'b1;
      end
    end else begin
      if (z_mod5 <= 3'd2) begin
        mag = {1'b0, 3'd2 - z_mod5};
      end else begin
        mag = {1'b0, z_mod5 - 3'd2};
        neg = 1'b1;
      end
    end
  end

  assign coef_val  = neg ? (COEF_W'(Q) - COEF_W'(mag)) : COEF_W'(mag);

  assign handshake = (state == SCAN) && accept && coef_ready;
  assign step      = (state == SCAN) && (!accept || coef_ready);
  assign last_nib  = (nib_idx == NIB_W'(NIBS - 1));
  assign last_coef = (count == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (sha_valid) state_nx = SCAN;
      SCAN: begin
        if (handshake && last_coef)
          state_nx = DONE;
        else if (step && last_nib)
          state_nx = LOAD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eta4    <= 1'b0;
      word_q  <= '0;
      nib_idx <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            eta4  <= eta_sel;
            count <= '0;
          end
        end
        LOAD: begin
          if (sha_valid) begin
            word_q  <= sha_data;
            nib_idx <= '0;
          end
        end
        SCAN: begin
          if (handshake)
            count <= count + 1'b1;
          if (step)
            nib_idx <= nib_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sha_ready  = (state == LOAD);
    busy       = (state == LOAD) || (state == SCAN);
    done       = (state == DONE);
    coef_valid = (state == SCAN) && accept;
    coef_data  = coef_valid ? coef_val : '0;
    coef_idx   = coef_valid ? 8'(count) : 8'd0;
  end

endmodule
